inpkt_reader: RTL and testbench
===============================

// Module: inpkt_reader
// PURPOSE
//  Byte-level input packet parser. Sits directly downstream of the 16->8 input
//  FIFO read side (FWFT). Parses header, streams payload bytes to the consumer
//  with valid/ready, verifies header and payload checksums, and latches errors.
// PARAMETERS
//  VERSION      2      required header version byte
//  MAX_LEN      65536  largest legal payload length in bytes; 0 is always illegal
// PORTS
//  clk          in   1   single clock (FIFO rd_clk domain)
//  rst          in   1   asynchronous reset, active-high
//  din          in   8   FIFO dout (FWFT)
//  empty        in   1   FIFO empty
//  rd_en        out  1   FIFO read strobe
//  dout         out  8   payload byte
//  dout_valid   out  1   dout holds a payload byte
//  dout_ready   in   1   consumer accepts dout this cycle
//  pkt_type     out  8   type of current packet, valid from first payload byte
//  pkt_id       out  16  id of current packet, valid from first payload byte
//  pkt_end      out  1   qualifies dout: last payload byte of packet
//  pkt_done     out  1   1-cycle pulse after trailer checked OK
//  err_hdr      out  1   sticky: bad version, length or header checksum
//  err_csum     out  1   sticky: payload checksum mismatch
// BEHAVIOUR
//  Reset (async): state HDR, all outputs 0, counters 0. Reset mid-packet drops
//   the packet; parsing resumes at the next byte as a header byte.
//  Packet: 8-byte header: VER, TYPE, LEN[7:0], LEN[15:8], LEN[23:16], ID[7:0],
//   ID[15:8], HCS. HCS = ~(sum of bytes 0..6) mod 256. Then LEN payload bytes,
//   then 2-byte trailer CS[7:0], CS[15:8] = sum of payload bytes mod 2^16.
//  FSM: HDR -> DATA after byte 7 if VER==VERSION, 1<=LEN<=MAX_LEN, HCS OK;
//   else -> ERR with err_hdr=1. DATA -> CSUM after LEN-th byte read.
//   CSUM -> HDR after 2nd trailer byte; match: pkt_done pulse; mismatch: -> ERR,
//   err_csum=1. ERR is terminal until rst: rd_en=0, dout_valid=0.
//  Handshake: rd_en = ~empty & (state HDR or CSUM, or state DATA with
//   (~dout_valid | dout_ready)). A byte is consumed in a cycle with rd_en=1.
//  Latency: payload byte read in cycle N appears on dout with dout_valid=1 at
//   N+1; held stable until dout_valid & dout_ready. Full throughput 1 byte/clk
//   under dout_ready=1. Header/trailer bytes never appear on dout.
//  Trailer bytes may be read while last payload byte still waits on dout;
//   pkt_done fires no earlier than the cycle that byte is accepted.
//  Counters: 24-bit payload down-counter; 16-bit wrapping checksum adder.
//  empty=1 in any state: rd_en=0, state and counters hold.
// CONFIGURATION
//  INPKT_CSUM_CHECK_EN defined: payload checksum compared as above.
//  Undefined: trailer bytes consumed and discarded, no compare, err_csum tied 0,
//   pkt_done fires after every trailer; checksum adder not instantiated.
// STRUCTURE
//  Shared include inpkt.vh: header length 8, trailer length 2, header byte
//   offsets, FSM state encodings, LEN/ID widths.
//  Sub-module inpkt_csum: 16-bit accumulator (clear, add byte, compare 2 bytes).
// TESTING
//  1. VER=2,TYPE=1,LEN=3,ID=0x1234,good HCS, data 0x11 0x22 0x33, CS=0x0066,
//     dout_ready=1 -> dout 11,22,33, pkt_end on 33, pkt_type=1, pkt_id=0x1234,
//     pkt_done once, no errors.
//  2. Same packet with HCS+1 -> err_hdr=1, no dout_valid, rd_en stays 0.
//  3. LEN=0, then LEN=65537 -> err_hdr=1 each (reset between).
//  4. Trailer CS=0x0067 -> err_csum=1, no pkt_done; with macro undefined ->
//     pkt_done, err_csum=0.
//  5. dout_ready toggled 1/0 every cycle, empty random 30% -> identical byte
//     sequence, dout stable while stalled, back-to-back packets parse.
//  6. rst pulse after 2nd payload byte, then fresh good packet -> all outputs 0
//     during reset, new packet delivered intact.

Source files
------------

// File: rtl/inpkt_reader_pkg.sv
// Shared constants, header layout and FSM encoding for the input packet reader.
// Optional payload checksum compare is enabled by defining INPKT_CSUM_CHECK_EN.
package inpkt_reader_pkg;

  localparam int HDR_LEN = 8;
  localparam int TRL_LEN = 2;
  localparam int HDR_IDX_W = $clog2(HDR_LEN);
  localparam int TRL_IDX_W = $clog2(TRL_LEN);
  localparam int LEN_W = 24;
  localparam int ID_W = 16;
  localparam int CSUM_W = 16;

  localparam logic [HDR_IDX_W-1:0] OFF_VER  = 3'd0;
  localparam logic [HDR_IDX_W-1:0] OFF_TYPE = 3'd1;
  localparam logic [HDR_IDX_W-1:0] OFF_LEN0 = 3'd2;
  localparam logic [HDR_IDX_W-1:0] OFF_LEN1 = 3'd3;
  localparam logic [HDR_IDX_W-1:0] OFF_LEN2 = 3'd4;
  localparam logic [HDR_IDX_W-1:0] OFF_ID0  = 3'd5;
  localparam logic [HDR_IDX_W-1:0] OFF_ID1  = 3'd6;
  localparam logic [HDR_IDX_W-1:0] OFF_HCS  = HDR_IDX_W'(HDR_LEN - 1);

  localparam logic [7:0] DEF_VERSION = 8'd2;
  localparam logic [LEN_W-1:0] DEF_MAX_LEN = 24'd65536;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_DATA = 2'd1,
    ST_CSUM = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/inpkt_reader_csum.sv
// 16-bit wrapping payload checksum accumulator with trailer compare.
// Instantiated by inpkt_reader only when INPKT_CSUM_CHECK_EN is defined.
module inpkt_reader_csum
  import inpkt_reader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] data,
  input  logic [7:0] cs_lo,
  input  logic [7:0] cs_hi,
  output logic       match
);

  logic [CSUM_W-1:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + {8'h00, data};
    end
  end

  assign match = (acc == {cs_hi, cs_lo});

endmodule

// File: rtl/inpkt_reader.sv
// Byte-level packet parser behind a FWFT FIFO: header check, payload stream,
// trailer checksum. Define INPKT_CSUM_CHECK_EN to compare the payload checksum.
module inpkt_reader
  import inpkt_reader_pkg::*;
#(
  parameter logic [7:0]       VERSION = DEF_VERSION,
  parameter logic [LEN_W-1:0] MAX_LEN = DEF_MAX_LEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      din,
  input  logic            empty,
  output logic            rd_en,
  output logic [7:0]      dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [7:0]      pkt_type,
  output logic [ID_W-1:0] pkt_id,
  output logic            pkt_end,
  output logic            pkt_done,
  output logic            err_hdr,
  output logic            err_csum
);

  state_e state_q, state_d;

  logic [HDR_IDX_W-1:0] hdr_idx;
  logic [TRL_IDX_W-1:0] trl_idx;
  logic [7:0]           hdr_ver;
  logic [7:0]           hdr_type;
  logic [7:0]           hdr_sum;
  logic [LEN_W-1:0]     hdr_len;
  logic [ID_W-1:0]      hdr_id;
  logic [LEN_W-1:0]     cnt;
  logic                 first_q;
  logic                 done_pend;

  logic hdr_last, hdr_ok, trl_last, trl_ok, cnt_last, hdr_acc;

  assign hdr_last = (hdr_idx == OFF_HCS);
  assign trl_last = (trl_idx == TRL_IDX_W'(TRL_LEN - 1));
  assign cnt_last = (cnt == 24'd1);
  assign hdr_ok = (hdr_ver == VERSION)
                & (hdr_len != '0)
                & (hdr_len <= MAX_LEN)
                & (din == ~hdr_sum);
  assign hdr_acc = rd_en & (state_q == ST_HDR) & hdr_last & hdr_ok;

`ifdef INPKT_CSUM_CHECK_EN
  logic [7:0] cs_lo;
  logic       cs_match;

  inpkt_reader_csum u_csum (
    .clk   (clk),
    .rst   (rst),
    .clr   (hdr_acc),
    .add   (rd_en & (state_q == ST_DATA)),
    .data  (din),
    .cs_lo (cs_lo),
    .cs_hi (din),
    .match (cs_match)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_lo <= '0;
    end else if (rd_en && state_q == ST_CSUM && !trl_last) begin
      cs_lo <= din;
    end
  end

  assign trl_ok = cs_match;
`else
  assign trl_ok = 1'b1;
`endif

  // Reset also masks the strobe so nothing is popped while held in reset.
  always_comb begin
    rd_en = 1'b0;
    unique case (1'b1)
      (state_q == ST_HDR),
      (state_q == ST_CSUM): rd_en = ~empty;
      (state_q == ST_DATA): rd_en = ~empty & (~dout_valid | dout_ready);
      default:              rd_en = 1'b0;
    endcase
    if (rst) rd_en = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HDR:  if (rd_en && hdr_last) state_d = hdr_ok ? ST_DATA : ST_ERR;
      ST_DATA: if (rd_en && cnt_last) state_d = ST_CSUM;
      ST_CSUM: if (rd_en && trl_last) state_d = trl_ok ? ST_HDR : ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HDR;
      hdr_idx    <= '0;
      trl_idx    <= '0;
      hdr_ver    <= '0;
      hdr_type   <= '0;
      hdr_sum    <= '0;
      hdr_len    <= '0;
      hdr_id     <= '0;
      cnt        <= '0;
      first_q    <= 1'b0;
      done_pend  <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      pkt_end    <= 1'b0;
      pkt_type   <= '0;
      pkt_id     <= '0;
      pkt_done   <= 1'b0;
      err_hdr    <= 1'b0;
      err_csum   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pkt_done <= 1'b0;
      if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
        pkt_end    <= 1'b0;
        if (done_pend) begin
          pkt_done  <= 1'b1;
          done_pend <= 1'b0;
        end
      end
      if (rd_en) begin
        unique case (state_q)
          ST_HDR: begin
            hdr_idx <= hdr_last ? '0 : hdr_idx + 1'b1;
            hdr_sum <= hdr_last ? '0 : hdr_sum + din;
            case (hdr_idx)
              OFF_VER:  hdr_ver <= din;
              OFF_TYPE: hdr_type <= din;
              OFF_LEN0: hdr_len[7:0] <= din;
              OFF_LEN1: hdr_len[15:8] <= din;
              OFF_LEN2: hdr_len[23:16] <= din;
              OFF_ID0:  hdr_id[7:0] <= din;
              OFF_ID1:  hdr_id[15:8] <= din;
              default: begin
                if (hdr_ok) begin
                  cnt     <= hdr_len;
                  first_q <= 1'b1;
                end else begin
                  err_hdr <= 1'b1;
                end
              end
            endcase
          end
          ST_DATA: begin
            dout       <= din;
            dout_valid <= 1'b1;
            pkt_end    <= cnt_last;
            cnt        <= cnt - 24'd1;
            // Header fields go out only once the previous packet's last byte has left.
            if (first_q) begin
              pkt_type <= hdr_type;
              pkt_id   <= hdr_id;
              first_q  <= 1'b0;
            end
          end
          ST_CSUM: begin
            trl_idx <= trl_last ? '0 : trl_idx + 1'b1;
            if (trl_last) begin
              if (!trl_ok) begin
                err_csum <= 1'b1;
              end else if (dout_valid && !dout_ready) begin
                done_pend <= 1'b1;
              end else begin
                pkt_done <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
      if (state_d == ST_ERR) begin
        dout_valid <= 1'b0;
        pkt_end    <= 1'b0;
        done_pend  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inpkt_reader.sv
// Directed self-checking bench for inpkt_reader: FWFT byte source model,
// payload sink monitor and per-scenario checking tasks.
module tb_inpkt_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  din = '0;
  logic        empty = 1'b1;
  logic        rd_en;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic [7:0]  pkt_type;
  logic [15:0] pkt_id;
  logic        pkt_end;
  logic        pkt_done;
  logic        err_hdr;
  logic        err_csum;

  int compared = 0;
  int mismatched = 0;

  logic [7:0]  src[$];
  logic [7:0]  rx_b[$];
  logic [7:0]  rx_t[$];
  logic [15:0] rx_id[$];
  logic        rx_end[$];
  int          done_cnt = 0;
  int          stall_err = 0;
  int          err_rd = 0;
  int          ready_mode = 0;
  int          gap_pct = 0;
  logic        took = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_dout = '0;

  inpkt_reader dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .empty      (empty),
    .rd_en      (rd_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .pkt_type   (pkt_type),
    .pkt_id     (pkt_id),
    .pkt_end    (pkt_end),
    .pkt_done   (pkt_done),
    .err_hdr    (err_hdr),
    .err_csum   (err_csum)
  );

  always #5 clk = ~clk;

  // FIFO source and payload sink, stepped once per clock on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (took && src.size() > 0) src.delete(0);
      if (src.size() > 0 && $urandom_range(99) >= gap_pct) begin
        empty = 1'b0;
        din = src[0];
      end else begin
        empty = 1'b1;
        din = 8'h00;
      end
      dout_ready = (ready_mode != 0) ? ~dout_ready : 1'b1;
      #1;
      took = rd_en & ~empty;
      if (!rst) begin
        if (prev_stall && (!dout_valid || dout !== prev_dout)) stall_err++;
        if (dout_valid && dout_ready) begin
          rx_b.push_back(dout);
          rx_t.push_back(pkt_type);
          rx_id.push_back(pkt_id);
          rx_end.push_back(pkt_end);
        end
        if (pkt_done) done_cnt++;
        if (rd_en && (err_hdr || err_csum)) err_rd++;
        prev_stall = dout_valid & ~dout_ready;
        prev_dout = dout;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    src.delete();
    took = 1'b0;
    rx_b.delete();
    rx_t.delete();
    rx_id.delete();
    rx_end.delete();
    done_cnt = 0;
    stall_err = 0;
    err_rd = 0;
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic push_pkt(input logic [7:0] ver, input logic [7:0] typ,
                          input logic [23:0] len, input logic [15:0] id,
                          input logic [7:0] hcs_adj, input logic [7:0] pl[$],
                          input logic [15:0] cs_adj);
    logic [7:0]  hb[7];
    logic [7:0]  hsum;
    logic [15:0] cs;
    hb[0] = ver;
    hb[1] = typ;
    hb[2] = len[7:0];
    hb[3] = len[15:8];
    hb[4] = len[23:16];
    hb[5] = id[7:0];
    hb[6] = id[15:8];
    hsum = '0;
    for (int i = 0; i < 7; i++) begin
      src.push_back(hb[i]);
      hsum = hsum + hb[i];
    end
    src.push_back(~hsum + hcs_adj);
    cs = '0;
    foreach (pl[i]) begin
      src.push_back(pl[i]);
      cs = cs + {8'h00, pl[i]};
    end
    cs = cs + cs_adj;
    src.push_back(cs[7:0]);
    src.push_back(cs[15:8]);
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
      if ((src.size() == 0 && !dout_valid) || err_hdr || err_csum) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) begin
      compared++;
      mismatched++;
      $display("FAIL %s timeout: src left %0d, required 0", name, src.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    src.push_back(8'h02);
    #3;
    compared++;
    if ({rd_en, dout, dout_valid, pkt_type, pkt_id, pkt_end, pkt_done,
         err_hdr, err_csum} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: rd_en=%b dout=%h vld=%b type=%h id=%h end=%b done=%b eh=%b ec=%b, required all 0",
               rd_en, dout, dout_valid, pkt_type, pkt_id, pkt_end, pkt_done, err_hdr, err_csum);
    end
    do_reset();
  endtask

  task automatic test_basic();
    logic [7:0] pl[$] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] exp_b[3] = '{8'h11, 8'h22, 8'h33};
    do_reset();
    ready_mode = 0;
    gap_pct = 0;
    push_pkt(8'h02, 8'h01, 24'd3, 16'h1234, 8'h00, pl, 16'h0000);
    wait_quiet("basic", 200);
    compared++;
    if (rx_b.size() != 3) begin
      mismatched++;
      $display("FAIL basic_count: got %0d bytes, required 3", rx_b.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (rx_b[i] !== exp_b[i] || rx_end[i] !== (i == 2) ||
            rx_t[i] !== 8'h01 || rx_id[i] !== 16'h1234) begin
          mismatched++;
          $display("FAIL basic_byte%0d: got %h end=%b type=%h id=%h, required %h end=%b type=01 id=1234",
                   i, rx_b[i], rx_end[i], rx_t[i], rx_id[i], exp_b[i], (i == 2));
        end
      end
    end
    compared++;
    if (done_cnt != 1 || err_hdr !== 1'b0 || err_csum !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_done: done=%0d eh=%b ec=%b, required 1 0 0", done_cnt, err_hdr, err_csum);
    end
  endtask

  task automatic test_bad_hcs();
    logic [7:0] pl[$] = '{8'h11, 8'h22, 8'h33};
    do_reset();
    push_pkt(8'h02, 8'h01, 24'd3, 16'h1234, 8'h01, pl, 16'h0000);
    wait_quiet("bad_hcs", 200);
    compared++;
    if (err_hdr !== 1'b1 || err_csum !== 1'b0) begin
      mismatched++;
      $display("FAIL bad_hcs_err: eh=%b ec=%b, required 1 0", err_hdr, err_csum);
    end
    compared++;
    if (rx_b.size() != 0 || dout_valid !== 1'b0 || rd_en !== 1'b0 ||
        err_rd != 0 || src.size() != 5) begin
      mismatched++;
      $display("FAIL bad_hcs_stop: rx=%0d vld=%b rd_en=%b err_rd=%0d left=%0d, required 0 0 0 0 5",
               rx_b.size(), dout_valid, rd_en, err_rd, src.size());
    end
  endtask

  task automatic test_bad_len();
    logic [7:0] pl[$] = '{8'h5a};
    logic [23:0] lens[2] = '{24'd0, 24'd65537};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      push_pkt(8'h02, 8'h03, lens[k], 16'h0001, 8'h00, pl, 16'h0000);
      wait_quiet("bad_len", 200);
      compared++;
      if (err_hdr !== 1'b1 || rx_b.size() != 0 || src.size() != 3) begin
        mismatched++;
        $display("FAIL bad_len_%0d: eh=%b rx=%0d left=%0d, required 1 0 3",
                 lens[k], err_hdr, rx_b.size(), src.size());
      end
    end
  endtask

  task automatic test_csum();
    logic [7:0] pl[$] = '{8'h11, 8'h22, 8'h33};
    do_reset();
    push_pkt(8'h02, 8'h01, 24'd3, 16'h1234, 8'h00, pl, 16'h0001);
    wait_quiet("csum", 200);
    compared++;
    if (rx_b.size() != 3 || rx_b[2] !== 8'h33) begin
      mismatched++;
      $display("FAIL csum_payload: got %0d bytes, required 3 ending 33", rx_b.size());
    end
    compared++;
`ifdef INPKT_CSUM_CHECK_EN
    if (err_csum !== 1'b1 || done_cnt != 0 || err_hdr !== 1'b0) begin
      mismatched++;
      $display("FAIL csum_bad: ec=%b done=%0d eh=%b, required 1 0 0", err_csum, done_cnt, err_hdr);
    end
`else
    if (err_csum !== 1'b0 || done_cnt != 1 || err_hdr !== 1'b0) begin
      mismatched++;
      $display("FAIL csum_ignored: ec=%b done=%0d eh=%b, required 0 1 0", err_csum, done_cnt, err_hdr);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa[$] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] pb[$] = '{8'hf0, 8'h01, 8'h80, 8'h7f, 8'hc3};
    logic [7:0] exp_b[8] = '{8'h11, 8'h22, 8'h33, 8'hf0, 8'h01, 8'h80, 8'h7f, 8'hc3};
    do_reset();
    ready_mode = 1;
    gap_pct = 30;
    push_pkt(8'h02, 8'h01, 24'd3, 16'h1234, 8'h00, pa, 16'h0000);
    push_pkt(8'h02, 8'h07, 24'd5, 16'hbeef, 8'h00, pb, 16'h0000);
    wait_quiet("b2b", 600);
    compared++;
    if (rx_b.size() != 8) begin
      mismatched++;
      $display("FAIL b2b_count: got %0d bytes, required 8", rx_b.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        compared++;
        if (rx_b[i] !== exp_b[i] || rx_end[i] !== (i == 2 || i == 7) ||
            rx_t[i] !== ((i < 3) ? 8'h01 : 8'h07) ||
            rx_id[i] !== ((i < 3) ? 16'h1234 : 16'hbeef)) begin
          mismatched++;
          $display("FAIL b2b_byte%0d: got %h end=%b type=%h id=%h, required %h",
                   i, rx_b[i], rx_end[i], rx_t[i], rx_id[i], exp_b[i]);
        end
      end
    end
    compared++;
    if (done_cnt != 2 || stall_err != 0 || err_hdr !== 1'b0 || err_csum !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_status: done=%0d stall_err=%0d eh=%b ec=%b, required 2 0 0 0",
               done_cnt, stall_err, err_hdr, err_csum);
    end
    ready_mode = 0;
    gap_pct = 0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] pa[$] = '{8'ha1, 8'ha2, 8'ha3, 8'ha4};
    logic [7:0] pb[$] = '{8'h42, 8'h24};
    int n = 0;
    do_reset();
    push_pkt(8'h02, 8'h09, 24'd4, 16'h5555, 8'h00, pa, 16'h0000);
    while (rx_b.size() < 2 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    compared++;
    if (rx_b.size() < 2) begin
      mismatched++;
      $display("FAIL rst_mid_wait: got %0d bytes, required 2", rx_b.size());
    end
    rst = 1'b1;
    #1;
    compared++;
    if ({rd_en, dout, dout_valid, pkt_type, pkt_id, pkt_end, pkt_done,
         err_hdr, err_csum} !== '0) begin
      mismatched++;
      $display("FAIL rst_mid_outputs: rd_en=%b dout=%h vld=%b type=%h id=%h end=%b, required all 0",
               rd_en, dout, dout_valid, pkt_type, pkt_id, pkt_end);
    end
    do_reset();
    push_pkt(8'h02, 8'h04, 24'd2, 16'h0a0b, 8'h00, pb, 16'h0000);
    wait_quiet("rst_mid", 200);
    compared++;
    if (rx_b.size() != 2 || rx_b[0] !== 8'h42 || rx_b[1] !== 8'h24 ||
        rx_end[1] !== 1'b1 || rx_t[0] !== 8'h04 || rx_id[0] !== 16'h0a0b ||
        done_cnt != 1 || err_hdr !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid_fresh: rx=%0d done=%0d eh=%b, required 2 bytes 42 24 type 04 id 0a0b done 1",
               rx_b.size(), done_cnt, err_hdr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_hcs();
    test_bad_len();
    test_csum();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
